// File: rtl/apb_pkg.sv
// Shared APB initiator definitions: FSM encoding, default widths and watchdog sizing.
package apb_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    // Counter must hold 0..TIMEOUT; keep at least one bit so a disabled watchdog still elaborates.
    function automatic int apb_timeout_w(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/apb_watchdog.sv
// ACCESS-phase pready watchdog: expire is a combinational pulse on the last allowed wait cycle.
module apb_watchdog
    import apb_pkg::*;
#(
    parameter int TIMEOUT = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic expire
);

    localparam int CW = apb_timeout_w(TIMEOUT);

    generate
        if (TIMEOUT == 0) begin : g_off
            logic unused_in;
            assign unused_in = ^{clk, rst, clear, count_en};
            assign expire    = 1'b0;
        end else begin : g_on
            localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
            logic [CW-1:0] cnt;

            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    cnt <= '0;
                else if (clear)
                    cnt <= '0;
                else if (count_en && !expire)
                    cnt <= cnt + 1'b1;
            end

            assign expire = count_en && (cnt == LAST);
        end
    endgenerate

endmodule

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB3 initiator: valid/ready request in, one-cycle completion pulse out.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = 256
) (
    input  logic              pclk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic [ADDR_W-1:0] paddr,
    output logic              pwrite,
    output logic              psel,
    output logic              penable,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    logic [1:0] state;
    logic       wd_expire;

    // psel/penable decode straight from state so an async reset drops them immediately.
    assign req_ready = (state == ST_IDLE) && !reset;
    assign psel      = (state != ST_IDLE);
    assign penable   = (state == ST_ACCESS);

    apb_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
        .clk      (pclk),
        .rst      (reset),
        .clear    (state == ST_SETUP),
        .count_en ((state == ST_ACCESS) && !pready),
        .expire   (wd_expire)
    );

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            paddr       <= '0;
            pwrite      <= 1'b0;
            pwdata      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        paddr  <= req_addr;
                        pwrite <= req_write;
                        pwdata <= req_wdata;
                        state  <= ST_SETUP;
                    end
                end
                ST_SETUP: state <= ST_ACCESS;
                ST_ACCESS: begin
                    // pready takes priority over a watchdog expiry on the same edge.
                    if (pready) begin
                        rsp_valid   <= 1'b1;
                        rsp_err     <= pslverr;
                        rsp_rdata   <= pwrite ? '0 : prdata;
                        rsp_timeout <= 1'b0;
                        state       <= ST_IDLE;
                    end else if (wd_expire) begin
                        rsp_valid   <= 1'b1;
                        rsp_err     <= 1'b1;
                        rsp_rdata   <= '0;
                        rsp_timeout <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
